// File: rtl/byte_lane_memory.sv
// Word-organised data RAM with byte/half/word stores, extending sub-word loads
// and a 1- or 2-cycle read path. Define MEM_BOUNDS_CHECK_EN to reject out-of-range addresses.
//
// state      | meaning
// -----------+-------------------------------------------------------------
// ST_IDLE    | accepting store and load requests
// ST_RD_PIPE | raw word captured, load result returned on the next edge
//            | (only reachable when READ_LATENCY = 2)

module byte_lane_memory #(
  parameter int ADDR_WIDTH   = 16,
  parameter int READ_LATENCY = 1
) (
  input  logic        clk,
  input  logic        reset_n,
  input  logic [31:0] wr_addr,
  input  logic [31:0] wr_data,
  input  logic [1:0]  wr_size,
  input  logic        wr_valid,
  output logic        wr_ready,
  output logic        wr_error,
  input  logic [31:0] rd_addr,
  input  logic [1:0]  rd_size,
  input  logic        rd_signed,
  input  logic        rd_valid,
  output logic [31:0] rd_data,
  output logic        rd_ready,
  output logic        rd_error
);

  localparam int DEPTH = 1 << ADDR_WIDTH;

  localparam logic [0:0] ST_IDLE    = 1'b0;
  localparam logic [0:0] ST_RD_PIPE = 1'b1;

  generate
    if (READ_LATENCY != 1 && READ_LATENCY != 2) begin : g_bad_latency
      $error("byte_lane_memory: READ_LATENCY must be 1 or 2");
    end
  endgenerate

  logic [31:0] mem [DEPTH];

  logic [0:0]            state;
  logic [ADDR_WIDTH-1:0] wr_idx;
  logic [ADDR_WIDTH-1:0] rd_idx;
  logic [3:0]            wr_mask;
  logic [31:0]           wr_word;
  logic [31:0]           rd_word;
  logic                  wr_oob;
  logic                  rd_oob;
  logic                  wr_err_now;
  logic                  rd_err_now;
  logic                  wr_accept;
  logic                  rd_accept;
  logic                  unused_upper_addr;

  logic [31:0] pipe_word;
  logic [1:0]  pipe_off;
  logic [1:0]  pipe_size;
  logic        pipe_signed;
  logic        pipe_err;

  function automatic logic misaligned(input logic [1:0] off, input logic [1:0] size);
    logic err;
    case (size)
      2'b00:   err = 1'b0;
      2'b01:   err = off[0];
      2'b10:   err = |off;
      default: err = 1'b1;
    endcase
    return err;
  endfunction

  function automatic logic [3:0] lane_mask(input logic [1:0] off, input logic [1:0] size);
    logic [3:0] m;
    case (size)
      2'b00:   m = 4'b0001 << off;
      2'b01:   m = off[1] ? 4'b1100 : 4'b0011;
      2'b10:   m = 4'b1111;
      default: m = 4'b0000;
    endcase
    return m;
  endfunction

  function automatic logic [31:0] replicate(input logic [31:0] data, input logic [1:0] size);
    logic [31:0] w;
    case (size)
      2'b00:   w = {4{data[7:0]}};
      2'b01:   w = {2{data[15:0]}};
      default: w = data;
    endcase
    return w;
  endfunction

  function automatic logic [31:0] extract(input logic [31:0] word, input logic [1:0] off,
                                          input logic [1:0] size, input logic sgn);
    logic [7:0]  b;
    logic [15:0] h;
    logic [31:0] r;
    b = 8'(word >> {off, 3'b000});
    h = off[1] ? word[31:16] : word[15:0];
    case (size)
      2'b00:   r = {{24{sgn & b[7]}}, b};
      2'b01:   r = {{16{sgn & h[15]}}, h};
      default: r = word;
    endcase
    return r;
  endfunction

  assign unused_upper_addr = ^{wr_addr[31:ADDR_WIDTH+2], rd_addr[31:ADDR_WIDTH+2]};

`ifdef MEM_BOUNDS_CHECK_EN
  assign wr_oob = |wr_addr[31:ADDR_WIDTH+2];
  assign rd_oob = |rd_addr[31:ADDR_WIDTH+2];
`else
  assign wr_oob = 1'b0;
  assign rd_oob = 1'b0;
`endif

  assign wr_idx     = wr_addr[ADDR_WIDTH+1:2];
  assign rd_idx     = rd_addr[ADDR_WIDTH+1:2];
  assign wr_mask    = lane_mask(wr_addr[1:0], wr_size);
  assign wr_word    = replicate(wr_data, wr_size);
  assign rd_word    = mem[rd_idx];
  assign wr_err_now = misaligned(wr_addr[1:0], wr_size) | wr_oob;
  assign rd_err_now = misaligned(rd_addr[1:0], rd_size) | rd_oob;

  // The ready terms block re-acceptance while a completion pulse is still up.
  assign wr_accept = (state == ST_IDLE) && wr_valid && !wr_ready;
  assign rd_accept = (state == ST_IDLE) && rd_valid && !rd_ready && !wr_accept;

  always_ff @(posedge clk) begin
    for (int k = 0; k < 4; k++) begin
      if (wr_accept && !wr_err_now && wr_mask[k]) begin
        mem[wr_idx][8*k +: 8] <= wr_word[8*k +: 8];
      end
    end
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state       <= ST_IDLE;
      wr_ready    <= 1'b0;
      wr_error    <= 1'b0;
      rd_ready    <= 1'b0;
      rd_error    <= 1'b0;
      rd_data     <= '0;
      pipe_word   <= '0;
      pipe_off    <= '0;
      pipe_size   <= '0;
      pipe_signed <= 1'b0;
      pipe_err    <= 1'b0;
    end else begin
      wr_ready <= wr_accept;
      wr_error <= wr_accept & wr_err_now;
      rd_ready <= 1'b0;
      rd_error <= 1'b0;
      case (state)
        ST_IDLE: begin
          if (rd_accept) begin
            if (READ_LATENCY == 2) begin
              pipe_word   <= rd_word;
              pipe_off    <= rd_addr[1:0];
              pipe_size   <= rd_size;
              pipe_signed <= rd_signed;
              pipe_err    <= rd_err_now;
              state       <= ST_RD_PIPE;
            end else begin
              rd_ready <= 1'b1;
              rd_error <= rd_err_now;
              if (!rd_err_now) begin
                rd_data <= extract(rd_word, rd_addr[1:0], rd_size, rd_signed);
              end
            end
          end
        end
        default: begin
          rd_ready <= 1'b1;
          rd_error <= pipe_err;
          if (!pipe_err) begin
            rd_data <= extract(pipe_word, pipe_off, pipe_size, pipe_signed);
          end
          state <= ST_IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_byte_lane_memory.sv
// Self-checking bench for byte_lane_memory: a latency-1 and a latency-2 instance,
// each checked against a byte-addressed reference model.

module tb_byte_lane_memory;

  localparam int AW     = 4;
  localparam int NBYTES = 4 << AW;
`ifdef MEM_BOUNDS_CHECK_EN
  localparam bit BOUNDS = 1'b1;
`else
  localparam bit BOUNDS = 1'b0;
`endif

  logic        clk;
  logic        reset_n;
  logic [31:0] wr_addr  [2];
  logic [31:0] wr_data  [2];
  logic [1:0]  wr_size  [2];
  logic        wr_valid [2];
  logic        wr_ready [2];
  logic        wr_error [2];
  logic [31:0] rd_addr  [2];
  logic [1:0]  rd_size  [2];
  logic        rd_signed[2];
  logic        rd_valid [2];
  logic [31:0] rd_data  [2];
  logic        rd_ready [2];
  logic        rd_error [2];

  logic [7:0]  model_mem [2][NBYTES];
  logic [31:0] exp_rd [2];
  int          n_pass;
  int          n_total;

  byte_lane_memory #(.ADDR_WIDTH(AW), .READ_LATENCY(1)) u_lat1 (
    .clk(clk), .reset_n(reset_n),
    .wr_addr(wr_addr[0]), .wr_data(wr_data[0]), .wr_size(wr_size[0]), .wr_valid(wr_valid[0]),
    .wr_ready(wr_ready[0]), .wr_error(wr_error[0]),
    .rd_addr(rd_addr[0]), .rd_size(rd_size[0]), .rd_signed(rd_signed[0]), .rd_valid(rd_valid[0]),
    .rd_data(rd_data[0]), .rd_ready(rd_ready[0]), .rd_error(rd_error[0])
  );

  byte_lane_memory #(.ADDR_WIDTH(AW), .READ_LATENCY(2)) u_lat2 (
    .clk(clk), .reset_n(reset_n),
    .wr_addr(wr_addr[1]), .wr_data(wr_data[1]), .wr_size(wr_size[1]), .wr_valid(wr_valid[1]),
    .wr_ready(wr_ready[1]), .wr_error(wr_error[1]),
    .rd_addr(rd_addr[1]), .rd_size(rd_size[1]), .rd_signed(rd_signed[1]), .rd_valid(rd_valid[1]),
    .rd_data(rd_data[1]), .rd_ready(rd_ready[1]), .rd_error(rd_error[1])
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  function automatic int lat(input int d);
    return d + 1;
  endfunction

  function automatic int nbytes(input logic [1:0] s);
    return (s == 2'd0) ? 1 : (s == 2'd1) ? 2 : 4;
  endfunction

  function automatic bit mdl_err(input logic [31:0] a, input logic [1:0] s);
    bit e;
    e = (s == 2'd3) || (s == 2'd1 && a % 2 != 0) || (s == 2'd2 && a % 4 != 0);
    if (BOUNDS && a >= NBYTES) e = 1'b1;
    return e;
  endfunction

  function automatic logic [31:0] mdl_load(input int d, input logic [31:0] a,
                                           input logic [1:0] s, input bit sg);
    int n;
    int base;
    logic [31:0] v;
    n = nbytes(s);
    base = int'(a % NBYTES);
    v = '0;
    for (int k = 0; k < n; k++) v = v | (32'(model_mem[d][base + k]) << (8 * k));
    if (sg && n < 4 && v[8*n-1]) v = v | (32'hFFFF_FFFF << (8 * n));
    return v;
  endfunction

  task automatic mdl_store(input int d, input logic [31:0] a, input logic [31:0] data,
                           input logic [1:0] s);
    int base;
    base = int'(a % NBYTES);
    for (int k = 0; k < nbytes(s); k++) model_mem[d][base + k] = data[8*k +: 8];
  endtask

  task automatic do_store(input int d, input logic [31:0] a, input logic [31:0] data,
                          input logic [1:0] s);
    bit e;
    bit got;
    int cyc;
    e = mdl_err(a, s);
    wr_addr[d] = a; wr_data[d] = data; wr_size[d] = s; wr_valid[d] = 1'b1;
    cyc = 0; got = 1'b0;
    while (!got && cyc < 8) begin
      @(posedge clk); #1;
      cyc++;
      got = wr_ready[d];
    end
    wr_valid[d] = 1'b0;
    n_total++;
    if (!got || cyc != 1) $display("FAIL store_latency d=%0d addr=%h: got %0d cycles (ready=%0b), want 1", d, a, cyc, got);
    else n_pass++;
    n_total++;
    if (wr_error[d] !== e) $display("FAIL store_error d=%0d addr=%h size=%0d: got %b, want %b", d, a, s, wr_error[d], e);
    else n_pass++;
    if (!e) mdl_store(d, a, data, s);
    @(posedge clk); #1;
    n_total++;
    if (wr_ready[d] !== 1'b0 || wr_error[d] !== 1'b0) $display("FAIL store_pulse d=%0d: got ready=%b error=%b, want 0 0", d, wr_ready[d], wr_error[d]);
    else n_pass++;
  endtask

  task automatic do_load(input int d, input logic [31:0] a, input logic [1:0] s, input bit sg);
    bit e;
    bit got;
    int cyc;
    logic [31:0] expv;
    e = mdl_err(a, s);
    expv = e ? exp_rd[d] : mdl_load(d, a, s, sg);
    rd_addr[d] = a; rd_size[d] = s; rd_signed[d] = sg; rd_valid[d] = 1'b1;
    cyc = 0; got = 1'b0;
    while (!got && cyc < 8) begin
      @(posedge clk); #1;
      cyc++;
      got = rd_ready[d];
    end
    rd_valid[d] = 1'b0;
    n_total++;
    if (!got || cyc != lat(d)) $display("FAIL load_latency d=%0d addr=%h: got %0d cycles (ready=%0b), want %0d", d, a, cyc, got, lat(d));
    else n_pass++;
    n_total++;
    if (rd_error[d] !== e) $display("FAIL load_error d=%0d addr=%h size=%0d: got %b, want %b", d, a, s, rd_error[d], e);
    else n_pass++;
    n_total++;
    if (rd_data[d] !== expv) $display("FAIL load_data d=%0d addr=%h size=%0d signed=%0b: got %h, want %h", d, a, s, sg, rd_data[d], expv);
    else n_pass++;
    exp_rd[d] = expv;
    @(posedge clk); #1;
    n_total++;
    if (rd_ready[d] !== 1'b0 || rd_error[d] !== 1'b0 || rd_data[d] !== expv)
      $display("FAIL load_pulse d=%0d: got ready=%b error=%b data=%h, want 0 0 %h", d, rd_ready[d], rd_error[d], rd_data[d], expv);
    else n_pass++;
  endtask

  task automatic test_reset();
    reset_n = 1'b0;
    for (int d = 0; d < 2; d++) begin
      wr_addr[d] = '0; wr_data[d] = '0; wr_size[d] = '0; wr_valid[d] = 1'b0;
      rd_addr[d] = '0; rd_size[d] = '0; rd_signed[d] = 1'b0; rd_valid[d] = 1'b0;
      exp_rd[d] = '0;
    end
    repeat (3) @(posedge clk);
    #1;
    for (int d = 0; d < 2; d++) begin
      n_total++;
      if ({wr_ready[d], wr_error[d], rd_ready[d], rd_error[d]} !== 4'b0000 || rd_data[d] !== 32'h0)
        $display("FAIL reset_state d=%0d: got flags=%b%b%b%b data=%h, want 0000 00000000", d, wr_ready[d], wr_error[d], rd_ready[d], rd_error[d], rd_data[d]);
      else n_pass++;
    end
    reset_n = 1'b1;
    @(posedge clk); #1;
  endtask

  task automatic test_init(input int d);
    for (int w = 0; w < NBYTES / 4; w++) do_store(d, 32'(w * 4), 32'h0, 2'd2);
  endtask

  task automatic test_directed(input int d);
    do_store(d, 32'h10, 32'hDEAD_BEEF, 2'd2);
    do_load(d, 32'h10, 2'd2, 1'b0);
    n_total++;
    if (rd_data[d] !== 32'hDEAD_BEEF) $display("FAIL word_load d=%0d: got %h, want deadbeef", d, rd_data[d]);
    else n_pass++;
    do_store(d, 32'h11, 32'h1234_56AA, 2'd0);
    do_load(d, 32'h10, 2'd2, 1'b0);
    n_total++;
    if (rd_data[d] !== 32'hDEAD_AAEF) $display("FAIL byte_merge d=%0d: got %h, want deadaaef", d, rd_data[d]);
    else n_pass++;
    do_load(d, 32'h11, 2'd0, 1'b1);
    n_total++;
    if (rd_data[d] !== 32'hFFFF_FFAA) $display("FAIL byte_signed d=%0d: got %h, want ffffffaa", d, rd_data[d]);
    else n_pass++;
    do_load(d, 32'h11, 2'd0, 1'b0);
    n_total++;
    if (rd_data[d] !== 32'h0000_00AA) $display("FAIL byte_unsigned d=%0d: got %h, want 000000aa", d, rd_data[d]);
    else n_pass++;
    do_load(d, 32'h12, 2'd1, 1'b1);
    n_total++;
    if (rd_data[d] !== 32'hFFFF_DEAD) $display("FAIL half_signed d=%0d: got %h, want ffffdead", d, rd_data[d]);
    else n_pass++;
    do_store(d, 32'h12, 32'h0000_7777, 2'd1);
    do_load(d, 32'h12, 2'd1, 1'b1);
    n_total++;
    if (rd_data[d] !== 32'h0000_7777) $display("FAIL half_store d=%0d: got %h, want 00007777", d, rd_data[d]);
    else n_pass++;
    do_store(d, 32'h13, 32'h0000_1111, 2'd1);
    do_load(d, 32'h10, 2'd2, 1'b0);
    n_total++;
    if (rd_data[d] !== 32'h7777_AAEF) $display("FAIL misaligned_store_kept d=%0d: got %h, want 7777aaef", d, rd_data[d]);
    else n_pass++;
    do_load(d, 32'h12, 2'd2, 1'b0);
    n_total++;
    if (rd_data[d] !== 32'h7777_AAEF || rd_error[d] !== 1'b0) $display("FAIL misaligned_load_hold d=%0d: got %h, want 7777aaef", d, rd_data[d]);
    else n_pass++;
    do_store(d, 32'h10, 32'h0BAD_0BAD, 2'd3);
    do_load(d, 32'h10, 2'd3, 1'b0);
    do_load(d, 32'h10, 2'd2, 1'b0);
  endtask

  task automatic test_simultaneous(input int d);
    int cyc;
    int wr_t;
    int rd_t;
    wr_t = 0; rd_t = 0; cyc = 0;
    wr_addr[d] = 32'h20; wr_data[d] = 32'h55AA_55AA; wr_size[d] = 2'd2; wr_valid[d] = 1'b1;
    rd_addr[d] = 32'h20; rd_size[d] = 2'd2; rd_signed[d] = 1'b0; rd_valid[d] = 1'b1;
    while (rd_t == 0 && cyc < 10) begin
      @(posedge clk); #1;
      cyc++;
      if (wr_ready[d]) begin wr_t = cyc; wr_valid[d] = 1'b0; end
      if (rd_ready[d]) begin rd_t = cyc; rd_valid[d] = 1'b0; end
    end
    wr_valid[d] = 1'b0; rd_valid[d] = 1'b0;
    n_total++;
    if (wr_t != 1 || rd_t != 1 + lat(d)) $display("FAIL collision_order d=%0d: got wr at %0d rd at %0d, want 1 and %0d", d, wr_t, rd_t, 1 + lat(d));
    else n_pass++;
    n_total++;
    if (rd_data[d] !== 32'h55AA_55AA) $display("FAIL collision_data d=%0d: got %h, want 55aa55aa", d, rd_data[d]);
    else n_pass++;
    mdl_store(d, 32'h20, 32'h55AA_55AA, 2'd2);
    exp_rd[d] = 32'h55AA_55AA;
    @(posedge clk); #1;
  endtask

  task automatic test_reset_mid_read();
    bit seen;
    rd_addr[1] = 32'h10; rd_size[1] = 2'd2; rd_signed[1] = 1'b0; rd_valid[1] = 1'b1;
    @(posedge clk); #1;
    rd_valid[1] = 1'b0;
    n_total++;
    if (rd_ready[1] !== 1'b0) $display("FAIL pipe_early_ready: got %b, want 0", rd_ready[1]);
    else n_pass++;
    reset_n = 1'b0;
    #1;
    for (int d = 0; d < 2; d++) begin
      n_total++;
      if ({wr_ready[d], wr_error[d], rd_ready[d], rd_error[d]} !== 4'b0000 || rd_data[d] !== 32'h0)
        $display("FAIL midread_reset d=%0d: got flags=%b%b%b%b data=%h, want 0000 00000000", d, wr_ready[d], wr_error[d], rd_ready[d], rd_error[d], rd_data[d]);
      else n_pass++;
      exp_rd[d] = '0;
    end
    #1 reset_n = 1'b1;
    seen = 1'b0;
    repeat (4) begin
      @(posedge clk); #1;
      if (rd_ready[1]) seen = 1'b1;
    end
    n_total++;
    if (seen) $display("FAIL midread_discard: got rd_ready after reset, want none");
    else n_pass++;
  endtask

  task automatic test_bounds(input int d);
    logic [31:0] want;
    want = BOUNDS ? 32'h0 : 32'hCAFE_F00D;
    do_store(d, 32'h100, 32'hCAFE_F00D, 2'd2);
    do_load(d, 32'h0, 2'd2, 1'b0);
    n_total++;
    if (rd_data[d] !== want) $display("FAIL bounds_word0 d=%0d: got %h, want %h", d, rd_data[d], want);
    else n_pass++;
  endtask

  task automatic test_back_to_back(input int d);
    bit got;
    int cyc;
    logic [31:0] expv;
    wr_size[d] = 2'd2; wr_addr[d] = 32'h14; wr_data[d] = $urandom; wr_valid[d] = 1'b1;
    for (int i = 0; i < 3; i++) begin
      cyc = 0; got = 1'b0;
      while (!got && cyc < 8) begin
        @(posedge clk); #1;
        cyc++;
        got = wr_ready[d];
      end
      n_total++;
      if (!got || cyc != (i == 0 ? 1 : 2)) $display("FAIL b2b_store d=%0d i=%0d: got %0d cycles, want %0d", d, i, cyc, (i == 0 ? 1 : 2));
      else n_pass++;
      mdl_store(d, wr_addr[d], wr_data[d], 2'd2);
      wr_addr[d] = wr_addr[d] + 32'd4; wr_data[d] = $urandom;
    end
    wr_valid[d] = 1'b0;
    @(posedge clk); #1;
    rd_size[d] = 2'd2; rd_signed[d] = 1'b0; rd_addr[d] = 32'h14; rd_valid[d] = 1'b1;
    for (int i = 0; i < 3; i++) begin
      expv = mdl_load(d, rd_addr[d], 2'd2, 1'b0);
      cyc = 0; got = 1'b0;
      while (!got && cyc < 8) begin
        @(posedge clk); #1;
        cyc++;
        got = rd_ready[d];
      end
      n_total++;
      if (!got || cyc != (i == 0 ? lat(d) : lat(d) + 1) || rd_data[d] !== expv)
        $display("FAIL b2b_load d=%0d i=%0d: got %0d cycles data %h, want %0d cycles data %h", d, i, cyc, rd_data[d], (i == 0 ? lat(d) : lat(d) + 1), expv);
      else n_pass++;
      exp_rd[d] = expv;
      rd_addr[d] = rd_addr[d] + 32'd4;
    end
    rd_valid[d] = 1'b0;
    @(posedge clk); #1;
  endtask

  task automatic test_random(input int d);
    logic [31:0] a;
    logic [1:0]  s;
    for (int i = 0; i < 150; i++) begin
      a = 32'($urandom_range(0, NBYTES - 1));
      s = 2'($urandom_range(0, 3));
      if ($urandom_range(0, 7) == 0) a = a | ($urandom & 32'hFFFF_FFC0);
      if ($urandom_range(0, 1) == 1) a = a & ~32'(nbytes(s) - 1);
      if ($urandom_range(0, 1) == 1) do_store(d, a, $urandom, s);
      else do_load(d, a, s, 1'($urandom_range(0, 1)));
    end
  endtask

  initial begin
    n_pass = 0;
    n_total = 0;
    test_reset();
    for (int d = 0; d < 2; d++) begin
      test_init(d);
      test_directed(d);
      test_simultaneous(d);
      test_bounds(d);
      test_back_to_back(d);
    end
    test_reset_mid_read();
    for (int d = 0; d < 2; d++) test_random(d);
    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
